// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: write/read slot counters, handshake strobes and level tracking.
// Optional sticky overflow/underflow flags with err_clear_i: define FIFO_SYNC_CTRL_ERROR_EN.

module fifo_counter #(
  parameter int DEPTH = 8,
  parameter int STEP  = 8,
  parameter int AW    = 6,
  parameter int PW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic [AW-1:0] addr_o,
  output logic [PW-1:0] ptr_o
);
  localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  logic [PW-1:0] idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;

  // The bit address is carried alongside the slot index so no multiplier is needed.
  always_comb begin
    idx_d  = idx_q;
    addr_d = addr_q;
    if (en_i) begin
      if (idx_q == LAST) begin
        idx_d  = '0;
        addr_d = '0;
      end else begin
        idx_d  = idx_q + PW'(1);
        addr_d = addr_q + STEP_A;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      addr_q <= '0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign ptr_o  = idx_q ^ (idx_q >> 1);
endmodule

module fifo_sync_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  wr_valid_i,
  output logic                                  wr_ready_o,
  output logic                                  rd_valid_o,
  input  logic                                  rd_ready_i,
  output logic                                  wr_enable_o,
  output logic                                  rd_enable_o,
  output logic [$clog2(DATA_WIDTH*DEPTH)-1:0]   wr_address_o,
  output logic [$clog2(DATA_WIDTH*DEPTH)-1:0]   rd_address_o,
  output logic [$clog2(DEPTH)-1:0]              wr_ptr_o,
  output logic [$clog2(DEPTH)-1:0]              rd_ptr_o,
  output logic [$clog2(DEPTH+1)-1:0]            level_o,
  output logic                                  full_o,
  output logic                                  empty_o
`ifdef FIFO_SYNC_CTRL_ERROR_EN
  ,
  input  logic                                  err_clear_i,
  output logic                                  overflow_err_o,
  output logic                                  underflow_err_o
`endif
);
  localparam int AW = $clog2(DATA_WIDTH*DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          wr_en, rd_en;

  // Strobes are gated by reset so storage never sees a write while held in reset.
  assign wr_en = wr_valid_i & ~full_q & rst_ni;
  assign rd_en = rd_ready_i & ~empty_q & rst_ni;

  fifo_counter #(.DEPTH(DEPTH), .STEP(DATA_WIDTH), .AW(AW), .PW(PW)) u_wr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (wr_en),
    .addr_o (wr_address_o),
    .ptr_o  (wr_ptr_o)
  );

  fifo_counter #(.DEPTH(DEPTH), .STEP(DATA_WIDTH), .AW(AW), .PW(PW)) u_rd_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (rd_en),
    .addr_o (rd_address_o),
    .ptr_o  (rd_ptr_o)
  );

  always_comb begin
    level_d = level_q;
    if (wr_en && !rd_en) begin
      level_d = level_q + LW'(1);
    end else if (!wr_en && rd_en) begin
      level_d = level_q - LW'(1);
    end
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign wr_ready_o  = ~full_q;
  assign rd_valid_o  = ~empty_q;
  assign wr_enable_o = wr_en;
  assign rd_enable_o = rd_en;
  assign level_o     = level_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

`ifdef FIFO_SYNC_CTRL_ERROR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // A new refused request outranks a clear on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clear_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_valid_i && full_q) ovf_d = 1'b1;
    if (rd_ready_i && empty_q) unf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = unf_q;
`endif

  a_level_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) level_q <= DEPTH_L);
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl: DEPTH=4 and DEPTH=5 instances share one random stimulus stream,
// each checked against a queue-based reference model.

module tb_fifo_sync_ctrl;
  localparam int DW = 8;
  localparam int D0 = 4;
  localparam int D1 = 5;

  typedef struct {
    bit wen, ren, wrdy, rval, full, empty, ovf, unf;
    int wa, ra, wp, rp, lvl;
  } exp_t;

  logic clk, rst_n, wr_valid, rd_ready, err_clear;

  logic       wr_ready0, rd_valid0, wen0, ren0, full0, empty0;
  logic [4:0] wa0, ra0;
  logic [1:0] wp0, rp0;
  logic [2:0] lvl0;
  logic       wr_ready1, rd_valid1, wen1, ren1, full1, empty1;
  logic [5:0] wa1, ra1;
  logic [2:0] wp1, rp1;
  logic [2:0] lvl1;
  logic       ovf0, unf0, ovf1, unf1;

  fifo_sync_ctrl #(.DATA_WIDTH(DW), .DEPTH(D0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready0),
    .rd_valid_o(rd_valid0), .rd_ready_i(rd_ready), .wr_enable_o(wen0), .rd_enable_o(ren0),
    .wr_address_o(wa0), .rd_address_o(ra0), .wr_ptr_o(wp0), .rd_ptr_o(rp0),
    .level_o(lvl0), .full_o(full0), .empty_o(empty0)
`ifdef FIFO_SYNC_CTRL_ERROR_EN
    , .err_clear_i(err_clear), .overflow_err_o(ovf0), .underflow_err_o(unf0)
`endif
  );

  fifo_sync_ctrl #(.DATA_WIDTH(DW), .DEPTH(D1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready1),
    .rd_valid_o(rd_valid1), .rd_ready_i(rd_ready), .wr_enable_o(wen1), .rd_enable_o(ren1),
    .wr_address_o(wa1), .rd_address_o(ra1), .wr_ptr_o(wp1), .rd_ptr_o(rp1),
    .level_o(lvl1), .full_o(full1), .empty_o(empty1)
`ifdef FIFO_SYNC_CTRL_ERROR_EN
    , .err_clear_i(err_clear), .overflow_err_o(ovf1), .underflow_err_o(unf1)
`endif
  );

`ifndef FIFO_SYNC_CTRL_ERROR_EN
  assign ovf0 = 1'b0;
  assign unf0 = 1'b0;
  assign ovf1 = 1'b0;
  assign unf1 = 1'b0;
`endif

  int a_wa[2], a_ra[2], a_wp[2], a_rp[2], a_lvl[2];
  bit a_wen[2], a_ren[2], a_wrdy[2], a_rval[2], a_full[2], a_empty[2], a_ovf[2], a_unf[2];

  always_comb begin
    a_wa[0] = 32'(wa0);  a_ra[0] = 32'(ra0);  a_wp[0] = 32'(wp0);  a_rp[0] = 32'(rp0);
    a_lvl[0] = 32'(lvl0);
    a_wen[0] = wen0; a_ren[0] = ren0; a_wrdy[0] = wr_ready0; a_rval[0] = rd_valid0;
    a_full[0] = full0; a_empty[0] = empty0; a_ovf[0] = ovf0; a_unf[0] = unf0;
    a_wa[1] = 32'(wa1);  a_ra[1] = 32'(ra1);  a_wp[1] = 32'(wp1);  a_rp[1] = 32'(rp1);
    a_lvl[1] = 32'(lvl1);
    a_wen[1] = wen1; a_ren[1] = ren1; a_wrdy[1] = wr_ready1; a_rval[1] = rd_valid1;
    a_full[1] = full1; a_empty[1] = empty1; a_ovf[1] = ovf1; a_unf[1] = unf1;
  end

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int   n_chk = 0;
  int   n_fail = 0;
  int   mq[2][$];
  int   wcnt[2], rcnt[2];
  bit   ovf_m[2], unf_m[2];
  exp_t sb[2][$];

  function automatic int dep(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic int gray(input int i);
    return i ^ (i >> 1);
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL d%0d.%s: got %0d expected %0d at %0t", k, nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      wcnt[k] = 0; rcnt[k] = 0;
      ovf_m[k] = 1'b0; unf_m[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit wv, input bit rr, input bit ec);
    exp_t e;
    int   lvl = mq[k].size();
    bit   f   = (lvl == dep(k));
    bit   em  = (lvl == 0);
    e.wen = wv && !f;  e.ren = rr && !em;
    e.wrdy = !f;       e.rval = !em;
    e.full = f;        e.empty = em;   e.lvl = lvl;
    e.wa = wcnt[k] * DW;
    e.wp = gray(wcnt[k]);
    e.rp = gray(rcnt[k]);
    e.ra = em ? rcnt[k] * DW : mq[k][0] * DW;
    e.ovf = ovf_m[k];  e.unf = unf_m[k];
    sb[k].push_back(e);
    if (e.wen) begin
      mq[k].push_back(wcnt[k]);
      wcnt[k] = (wcnt[k] + 1) % dep(k);
    end
    if (e.ren) begin
      void'(mq[k].pop_front());
      rcnt[k] = (rcnt[k] + 1) % dep(k);
    end
    if (wv && f) ovf_m[k] = 1'b1; else if (ec) ovf_m[k] = 1'b0;
    if (rr && em) unf_m[k] = 1'b1; else if (ec) unf_m[k] = 1'b0;
  endtask

  task automatic cycle(input bit wv, input bit rr, input bit ec);
    @(negedge clk);
    wr_valid = wv; rd_ready = rr; err_clear = ec;
    #1;
    for (int k = 0; k < 2; k++) model_step(k, wv, rr, ec);
  endtask

  task automatic check_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst.level", k, a_lvl[k], 0);
      chk("rst.empty", k, 32'(a_empty[k]), 1);
      chk("rst.full", k, 32'(a_full[k]), 0);
      chk("rst.wr_ready", k, 32'(a_wrdy[k]), 1);
      chk("rst.rd_valid", k, 32'(a_rval[k]), 0);
      chk("rst.wr_enable", k, 32'(a_wen[k]), 0);
      chk("rst.rd_enable", k, 32'(a_ren[k]), 0);
      chk("rst.wr_address", k, a_wa[k], 0);
      chk("rst.rd_address", k, a_ra[k], 0);
      chk("rst.wr_ptr", k, a_wp[k], 0);
      chk("rst.rd_ptr", k, a_rp[k], 0);
`ifdef FIFO_SYNC_CTRL_ERROR_EN
      chk("rst.overflow_err", k, 32'(a_ovf[k]), 0);
      chk("rst.underflow_err", k, 32'(a_unf[k]), 0);
`endif
    end
  endtask

  // Monitor: pops one expectation per instance per cycle, decoupled from the stimulus process.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if (sb[k].size() > 0) begin
          e = sb[k].pop_front();
          chk("wr_enable", k, 32'(a_wen[k]), 32'(e.wen));
          chk("rd_enable", k, 32'(a_ren[k]), 32'(e.ren));
          chk("wr_ready", k, 32'(a_wrdy[k]), 32'(e.wrdy));
          chk("rd_valid", k, 32'(a_rval[k]), 32'(e.rval));
          chk("full", k, 32'(a_full[k]), 32'(e.full));
          chk("empty", k, 32'(a_empty[k]), 32'(e.empty));
          chk("level", k, a_lvl[k], e.lvl);
          chk("wr_address", k, a_wa[k], e.wa);
          chk("wr_ptr", k, a_wp[k], e.wp);
          chk("rd_ptr", k, a_rp[k], e.rp);
          if (a_rval[k]) chk("rd_address", k, a_ra[k], e.ra);
`ifdef FIFO_SYNC_CTRL_ERROR_EN
          chk("overflow_err", k, 32'(a_ovf[k]), 32'(e.ovf));
          chk("underflow_err", k, 32'(a_unf[k]), 32'(e.unf));
`endif
        end
      end
    end
  end

  initial begin : stimulus
    int pw[6] = '{80, 30, 50, 95, 10, 90};
    int pr[6] = '{30, 80, 50, 95, 90, 10};
    rst_n = 1'b0; wr_valid = 1'b1; rd_ready = 1'b1; err_clear = 1'b0;
    model_reset();
    #15;
    check_reset();
    @(negedge clk);
    wr_valid = 1'b0; rd_ready = 1'b0;
    #3 rst_n = 1'b1;

    // Fill past both depths, drain, then wrap the write side.
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(0, 0, 0);

    // Asynchronous reset between edges with the DEPTH=4 instance at level 3.
    @(negedge clk);
    wr_valid = 1'b1; rd_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_reset();
    #1 begin wr_valid = 1'b0; rd_ready = 1'b0; end
    #1 rst_n = 1'b1;
    model_reset();

    // Underflow attempts on empty, then an error clear.
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);

    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 100; i++) begin
        cycle($urandom_range(99) < pw[b], $urandom_range(99) < pr[b], $urandom_range(99) < 5);
      end
    end
    cycle(0, 0, 0);
    @(negedge clk);
    #4;
    for (int k = 0; k < 2; k++) chk("scoreboard_drained", k, sb[k].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
